ball_bouncer: RTL

- Parametrised moving-ball generator; successor to the fixed 4-pixel test ball.
- Sits between vga_sync and the RGB output register.
- Consumes pixel coordinates and the pixel tick, and moves a square ball of configurable size by a runtime speed once per frame.
- Bounces the ball off all four screen edges and counts bounces.

---
 rtl/ball_pkg.sv | 7 +
 rtl/ball_axis.sv | 72 +++++++
 rtl/ball_bouncer.sv | 100 ++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Shared types and widths for the moving-ball generator.
package ball_pkg;
    typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y} mv_state_t;
    typedef logic [11:0] rgb_t;
    localparam int SPEED_W  = 4;
    localparam int BOUNCE_W = 8;
endpackage

// File: rtl/ball_axis.sv
// One axis of ball motion: advances position by spd_i when stepped and
// clamps to the screen edge with a direction flip and a one-clk hit pulse.
module ball_axis
    import ball_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int ACTIVE    = 640,
    parameter int BALL_SIZE = 8,
    parameter int INIT      = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_i,
    input  logic [SPEED_W-1:0] spd_i,
    output logic [COORD_W-1:0] pos_o,
    output logic               dir_o,
    output logic               hit_o
);
    localparam logic [COORD_W:0]   MAX_EXT = (COORD_W+1)'(ACTIVE - BALL_SIZE);
    localparam logic [COORD_W-1:0] MAX_POS = COORD_W'(ACTIVE - BALL_SIZE);
    localparam logic [COORD_W-1:0] INIT_POS = COORD_W'(INIT);

    logic [COORD_W-1:0] pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               hit;
    logic [COORD_W:0]   pos_ext, spd_ext, sum, diff;

    assign pos_ext = {1'b0, pos_q};
    assign spd_ext = (COORD_W+1)'(spd_i);
    assign sum     = pos_ext + spd_ext;
    assign diff    = pos_ext - spd_ext;

    // dir_q: 0 moves toward larger coordinates, 1 toward zero
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        hit   = 1'b0;
        if (step_i && (spd_i != '0)) begin
            if (!dir_q) begin
                if (sum > MAX_EXT) begin
                    pos_d = MAX_POS;
                    dir_d = 1'b1;
                    hit   = 1'b1;
                end else begin
                    pos_d = sum[COORD_W-1:0];
                end
            end else begin
                if (pos_ext < spd_ext) begin
                    pos_d = '0;
                    dir_d = 1'b0;
                    hit   = 1'b1;
                end else begin
                    pos_d = diff[COORD_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= INIT_POS;
            dir_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos_o = pos_q;
    assign dir_o = dir_q;
    assign hit_o = hit;
endmodule

// File: rtl/ball_bouncer.sv
// Moving-ball generator: per-frame motion FSM, bounce counter and registered render.
//   state  | meaning
//   IDLE   | waiting for frame_tick (held here while paused)
//   MOVE_X | x axis steps by spd_q
//   MOVE_Y | y axis steps by spd_q
module ball_bouncer
    import ball_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BALL_SIZE = 8,
    parameter int INIT_X    = 316,
    parameter int INIT_Y    = 236,
    parameter int RGB_W     = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                p_tick,
    input  logic                video_on,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    input  logic [SPEED_W-1:0]  speed,
    input  logic                pause,
    input  logic [RGB_W-1:0]    ball_color,
    input  logic [RGB_W-1:0]    bg_color,
    output logic [RGB_W-1:0]    rgb,
    output logic [COORD_W-1:0]  ball_x,
    output logic [COORD_W-1:0]  ball_y,
    output logic [BOUNCE_W-1:0] bounce_cnt,
    output logic                frame_tick
);
    localparam logic [COORD_W:0] SIZE_EXT = (COORD_W+1)'(BALL_SIZE);

    mv_state_t           state_q, state_d;
    logic [SPEED_W-1:0]  spd_q, spd_d;
    logic                frame_tick_q, frame_tick_d;
    logic [BOUNCE_W-1:0] bounce_cnt_q, bounce_cnt_d;
    logic [RGB_W-1:0]    rgb_q, rgb_d;
    logic                hit_x, hit_y, on_ball;

    ball_axis #(.COORD_W(COORD_W), .ACTIVE(H_ACTIVE), .BALL_SIZE(BALL_SIZE), .INIT(INIT_X))
    u_axis_x (
        .clk(clk), .reset(reset), .step_i(state_q == MOVE_X), .spd_i(spd_q),
        .pos_o(ball_x), .dir_o(), .hit_o(hit_x)
    );

    ball_axis #(.COORD_W(COORD_W), .ACTIVE(V_ACTIVE), .BALL_SIZE(BALL_SIZE), .INIT(INIT_Y))
    u_axis_y (
        .clk(clk), .reset(reset), .step_i(state_q == MOVE_Y), .spd_i(spd_q),
        .pos_o(ball_y), .dir_o(), .hit_o(hit_y)
    );

    // First pixel of vertical blank marks the frame boundary
    assign frame_tick_d = p_tick && (x == '0) && (y == COORD_W'(V_ACTIVE));

    always_comb begin
        state_d = state_q;
        spd_d   = spd_q;
        case (state_q)
            IDLE: if (frame_tick_q && !pause) begin
                state_d = MOVE_X;
                spd_d   = speed;
            end
            MOVE_X:  state_d = MOVE_Y;
            MOVE_Y:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bounce_cnt_d = bounce_cnt_q + BOUNCE_W'(hit_x) + BOUNCE_W'(hit_y);

    assign on_ball = ({1'b0, x} >= {1'b0, ball_x}) && ({1'b0, x} < ({1'b0, ball_x} + SIZE_EXT)) &&
                     ({1'b0, y} >= {1'b0, ball_y}) && ({1'b0, y} < ({1'b0, ball_y} + SIZE_EXT));

    always_comb begin
        rgb_d = rgb_q;
        if (p_tick) rgb_d = video_on ? (on_ball ? ball_color : bg_color) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            spd_q        <= '0;
            frame_tick_q <= 1'b0;
            bounce_cnt_q <= '0;
            rgb_q        <= '0;
        end else begin
            state_q      <= state_d;
            spd_q        <= spd_d;
            frame_tick_q <= frame_tick_d;
            bounce_cnt_q <= bounce_cnt_d;
            rgb_q        <= rgb_d;
        end
    end

    assign rgb        = rgb_q;
    assign bounce_cnt = bounce_cnt_q;
    assign frame_tick = frame_tick_q;
endmodule
